// File: rtl/pio_program_loader.sv
// Byte-serial loader for the PIO instruction memory and FSM config; write_en fires the cycle after the LO byte.
// byte_ready drops only during the single WRITE cycle; commands rejected while running still drain their payload.
module pio_program_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              err_clr,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [15:0]       instr_in,
    output logic              out_shiftdir,
    output logic              autopull,
    output logic [4:0]        pull_thresh,
    output logic              fsm_enable,
    output logic              busy,
    output logic              err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_CNT   = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_LO    = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_CFG   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              block_q, block_d;
    logic              reject_q, reject_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        remaining_q, remaining_d;
    logic [15:0]       instr_q, instr_d;
    logic              shiftdir_q, shiftdir_d;
    logic              autopull_q, autopull_d;
    logic [4:0]        thresh_q, thresh_d;
    logic              run_q, run_d;
    logic              err_q, err_d;
    logic              take;
    logic              err_set;

    assign byte_ready = (state_q != S_WRITE);
    assign take       = byte_valid && byte_ready;

    always_comb begin
        state_d     = state_q;
        block_d     = block_q;
        reject_d    = reject_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        instr_d     = instr_q;
        shiftdir_d  = shiftdir_q;
        autopull_d  = autopull_q;
        thresh_d    = thresh_q;
        run_d       = run_q;
        err_set     = 1'b0;
        case (state_q)
            S_IDLE: if (take) begin
                case (byte_data)
                    8'h01, 8'h05: begin
                        block_d  = (byte_data == 8'h05);
                        reject_d = run_q;
                        err_set  = run_q;
                        state_d  = S_ADDR;
                    end
                    8'h02: begin
                        block_d  = 1'b0;
                        reject_d = run_q;
                        err_set  = run_q;
                        state_d  = S_CFG;
                    end
                    8'h03:   run_d   = 1'b1;
                    8'h04:   run_d   = 1'b0;
                    default: err_set = 1'b1;
                endcase
            end
            S_ADDR: if (take) begin
                addr_d  = byte_data[ADDR_W-1:0];
                state_d = block_q ? S_CNT : S_HI;
            end
            S_CNT: if (take) begin
                remaining_d = {1'b0, byte_data[4:0]} + 6'd1;
                state_d     = S_HI;
            end
            S_HI: if (take) begin
                instr_d[15:8] = byte_data;
                state_d       = S_LO;
            end
            S_LO: if (take) begin
                instr_d[7:0] = byte_data;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                if (block_q && (remaining_q > 6'd1)) begin
                    remaining_d = remaining_q - 6'd1;
                    addr_d      = addr_q + ADDR_W'(1);
                    state_d     = S_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CFG: if (take) begin
                // A rejected SET_CONFIG still eats its byte but must not touch the FSM config.
                if (!reject_q) begin
                    shiftdir_d = byte_data[0];
                    autopull_d = byte_data[1];
                    thresh_d   = byte_data[6:2];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        err_d = (err_q && !err_clr) || err_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            block_q     <= 1'b0;
            reject_q    <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            instr_q     <= '0;
            shiftdir_q  <= 1'b0;
            autopull_q  <= 1'b0;
            thresh_q    <= '0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            reject_q    <= reject_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            instr_q     <= instr_d;
            shiftdir_q  <= shiftdir_d;
            autopull_q  <= autopull_d;
            thresh_q    <= thresh_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign write_en     = (state_q == S_WRITE) && !reject_q;
    assign write_addr   = addr_q;
    assign instr_in     = instr_q;
    assign out_shiftdir = shiftdir_q;
    assign autopull     = autopull_q;
    assign pull_thresh  = thresh_q;
    assign fsm_enable   = run_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;
endmodule

// File: tb/tb_pio_program_loader.sv
// Scoreboard bench: a command-level model predicts writes and config; a monitor checks every write_en.
module tb_pio_program_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready;
    logic       err_clr = 1'b0;
    logic       write_en;
    logic [4:0] write_addr;
    logic [15:0] instr_in;
    logic       out_shiftdir, autopull, fsm_enable, busy, err;
    logic [4:0] pull_thresh;

    pio_program_loader #(.ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .err_clr(err_clr), .write_en(write_en),
        .write_addr(write_addr), .instr_in(instr_in), .out_shiftdir(out_shiftdir),
        .autopull(autopull), .pull_thresh(pull_thresh), .fsm_enable(fsm_enable),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int writes_seen = 0;
    int writes_expected = 0;
    bit gap_en = 1'b0;

    logic [20:0] exp_q[$];
    logic [7:0]  cmd[$];
    bit          m_rej, m_run, m_err, m_dir, m_ap;
    logic [4:0]  m_thr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void push_write(input logic [4:0] a, input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back({a, hi, lo});
        writes_expected++;
    endfunction

    // Command-level model: collect the bytes of the current command and act when it is complete.
    function automatic void model_byte(input logic [7:0] b);
        int n;
        int idx;
        logic [4:0] base;
        cmd.push_back(b);
        n = cmd.size();
        if (n == 1) begin
            case (b)
                8'h01, 8'h02, 8'h05: begin
                    m_rej = m_run;
                    if (m_run) m_err = 1'b1;
                end
                8'h03: begin m_run = 1'b1; cmd.delete(); end
                8'h04: begin m_run = 1'b0; cmd.delete(); end
                default: begin m_err = 1'b1; cmd.delete(); end
            endcase
            return;
        end
        case (cmd[0])
            8'h01: if (n == 4) begin
                if (!m_rej) push_write(cmd[1][4:0], cmd[2], cmd[3]);
                cmd.delete();
            end
            8'h02: begin
                if (!m_rej) begin
                    m_dir = b[0];
                    m_ap  = b[1];
                    m_thr = b[6:2];
                end
                cmd.delete();
            end
            8'h05: if (n >= 5 && (n % 2) == 1) begin
                idx  = (n - 5) / 2;
                base = cmd[1][4:0];
                if (!m_rej) push_write(5'((int'(base) + idx) % 32), cmd[n-2], cmd[n-1]);
                if (idx == int'(cmd[2][4:0])) cmd.delete();
            end
            default: cmd.delete();
        endcase
    endfunction

    function automatic void model_reset();
        cmd.delete();
        m_rej = 1'b0; m_run = 1'b0; m_err = 1'b0;
        m_dir = 1'b0; m_ap = 1'b0; m_thr = 5'd0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit rdy;
        bit done;
        done = 1'b0;
        @(negedge clk);
        if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = byte_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else @(negedge clk);
        end
        #1 byte_valid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL byte_accept_timeout: byte 0x%0h not accepted within 20 cycles", b);
        end else begin
            model_byte(b);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic settle_and_check(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fsm_enable"}, fsm_enable, m_run);
        check({tag, "_err"}, err, m_err);
        check({tag, "_shiftdir"}, out_shiftdir, m_dir);
        check({tag, "_autopull"}, autopull, m_ap);
        check({tag, "_thresh"}, pull_thresh, m_thr);
    endtask

    task automatic check_reset_values();
        check("rst_write_en", write_en, 0);
        check("rst_write_addr", write_addr, 0);
        check("rst_instr_in", instr_in, 0);
        check("rst_shiftdir", out_shiftdir, 0);
        check("rst_autopull", autopull, 0);
        check("rst_thresh", pull_thresh, 0);
        check("rst_fsm_enable", fsm_enable, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_byte_ready", byte_ready, 1);
    endtask

    always @(negedge clk) begin
        if (rst && write_en) begin
            writes_seen++;
            check("write_byte_ready_low", byte_ready, 0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h with no write expected", write_addr, instr_in);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("write_addr", write_addr, e[20:16]);
                check("write_data", instr_in, e[15:0]);
            end
        end
    end

    initial begin
        logic [7:0] cnt;
        int kind;
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;

        send_byte(8'h01); send_byte(8'h07); send_byte(8'hAB); send_byte(8'hCD);
        settle_and_check("single");

        send_byte(8'h05); send_byte(8'h1E); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h33);
        settle_and_check("block_wrap");
        check("block_wrap_count", writes_seen, 4);

        send_byte(8'h02); send_byte(8'h5A);
        settle_and_check("cfg");
        check("cfg_thresh_22", pull_thresh, 22);
        check("cfg_autopull_1", autopull, 1);
        send_byte(8'h03);
        settle_and_check("run");
        check("run_enable", fsm_enable, 1);

        send_byte(8'h01); send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
        settle_and_check("reject");
        check("reject_err", err, 1);
        send_byte(8'h02); send_byte(8'h03);
        settle_and_check("reject_cfg");
        check("reject_cfg_kept", pull_thresh, 22);
        send_byte(8'h03);
        settle_and_check("run_again");
        send_byte(8'h04);
        clear_err();
        settle_and_check("halt_clr");
        check("halt_clr_err", err, 0);
        send_byte(8'h04);
        settle_and_check("halt_again");

        send_byte(8'h7E);
        settle_and_check("bad_op");
        check("bad_op_err", err, 1);
        clear_err();
        err_clr = 1'b1;
        send_byte(8'hC3);
        err_clr = 1'b0;
        settle_and_check("clr_and_err");
        check("clr_and_err_set", err, 1);

        send_byte(8'h01); send_byte(8'h05); send_byte(8'hAA);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'h02); send_byte(8'h01);
        settle_and_check("post_reset_cfg");
        check("post_reset_shiftdir", out_shiftdir, 1);

        gap_en = 1'b1;
        for (int c = 0; c < 150; c++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1: begin
                    send_byte(8'h01);
                    send_byte(8'($urandom_range(0, 255)));
                    send_byte(8'($urandom_range(0, 255)));
                    send_byte(8'($urandom_range(0, 255)));
                end
                2, 3: begin
                    send_byte(8'h05);
                    send_byte(8'($urandom_range(0, 255)));
                    cnt = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 5))};
                    send_byte(cnt);
                    for (int k = 0; k <= int'(cnt[4:0]); k++) begin
                        send_byte(8'($urandom_range(0, 255)));
                        send_byte(8'($urandom_range(0, 255)));
                    end
                end
                4: begin
                    send_byte(8'h02);
                    send_byte(8'($urandom_range(0, 255)));
                end
                5: send_byte(8'h03);
                6, 7: send_byte(8'h04);
                8: send_byte(8'($urandom_range(6, 255)));
                default: clear_err();
            endcase
            settle_and_check("rand");
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_write_count", writes_seen, writes_expected);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
